video_tracker: RTL

VIDEO_TRACKER -- requirements
Module: video_tracker

---
 rtl/video_tracker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_tracker.sv
// Video timing tracker: follows vSync/hSync/displayEnabled on pixel ticks and reports dot/line/frame coordinates.
// Optional statistics (lastFieldLines, errorCount) are built only when VIDEO_TRACKER_STATS_EN is defined.
module video_tracker #(
  parameter int ACTIVE_DOTS      = 720,
  parameter int FIELD_LINES      = 288,
  parameter int COORD_W          = 10,
  parameter int INTERLACED       = 1,
  parameter int VSYNC_ACTIVE_LOW = 1,
  parameter int ODD_HSYNC_LEVEL  = 1
) (
  input  logic               pixelClockX6,
  input  logic               reset,
  input  logic [2:0]         pixelClockPhase,
  input  logic               vSync,
  input  logic               hSync,
  input  logic               displayEnabled,
  output logic [COORD_W-1:0] fieldLineDot,
  output logic [COORD_W-1:0] fieldLine,
  output logic [COORD_W-1:0] frameLine,
  output logic               isFieldOdd,
  output logic               pixelValid,
  output logic               fieldStart,
  output logic               shortLine,
  output logic               lineOverflow,
  output logic               locked,
  output logic [COORD_W-1:0] lastFieldLines,
  output logic [7:0]         errorCount
);

  // state  | meaning
  // SEARCH | unlocked, waiting for the first vSync assertion
  // VSYNC  | inside vertical sync, counters held at zero
  // ACTIVE | counting dots and lines of the current field
  typedef enum logic [1:0] {SEARCH, VSYNC, ACTIVE} trackerState_e;

  localparam logic [COORD_W-1:0] LAST_DOT  = COORD_W'(ACTIVE_DOTS - 1);
  localparam logic [COORD_W-1:0] LAST_LINE = COORD_W'(FIELD_LINES - 1);
  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);

  trackerState_e state;
  logic vsActPrev;
  logic dePrev;
  logic lineAdvanced;
  logic fieldFull;

  logic tick;
  logic vsAct;
  logic vsRise;
  logic vsFall;
  logic deFall;
  logic activeDe;
  logic dotWrap;
  logic shortEnd;
  logic lineAdvReq;
  logic atLastLine;
  logic oddAtVs;
  logic [COORD_W-1:0] frameNext;

  assign tick       = (pixelClockPhase == 3'd0);
  assign vsAct      = (VSYNC_ACTIVE_LOW != 0) ? ~vSync : vSync;
  assign vsRise     = vsAct & ~vsActPrev;
  assign vsFall     = ~vsAct & vsActPrev;
  assign deFall     = dePrev & ~displayEnabled;
  assign activeDe   = (state == ACTIVE) & ~vsRise;
  assign dotWrap    = displayEnabled & (fieldLineDot == LAST_DOT);
  assign shortEnd   = deFall & ~lineAdvanced & (fieldLineDot != '0);
  assign lineAdvReq = activeDe & (dotWrap | shortEnd);
  assign atLastLine = (fieldLine == LAST_LINE);
  assign oddAtVs    = (hSync == (ODD_HSYNC_LEVEL != 0));
  assign frameNext  = (INTERLACED != 0) ? {fieldLine[COORD_W-2:0], ~isFieldOdd} : fieldLine;

  // fieldFull marks that the last line of the field has completed; only a
  // further line end beyond that point counts as an overflow.
  always_ff @(posedge pixelClockX6 or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      vsActPrev    <= 1'b0;
      dePrev       <= 1'b0;
      lineAdvanced <= 1'b0;
      fieldFull    <= 1'b0;
      fieldLineDot <= '0;
      fieldLine    <= '0;
      frameLine    <= '0;
      isFieldOdd   <= (INTERLACED != 0) ? 1'b0 : 1'b1;
      pixelValid   <= 1'b0;
      fieldStart   <= 1'b0;
      shortLine    <= 1'b0;
      lineOverflow <= 1'b0;
      locked       <= 1'b0;
    end else if (tick) begin
      vsActPrev  <= vsAct;
      dePrev     <= displayEnabled;
      frameLine  <= frameNext;
      pixelValid <= displayEnabled & locked & (state == ACTIVE);
      fieldStart <= 1'b0;
      shortLine  <= 1'b0;

      case (state)
        SEARCH: begin
          fieldLineDot <= '0;
          fieldLine    <= '0;
          lineAdvanced <= 1'b0;
          fieldFull    <= 1'b0;
          if (vsRise) state <= VSYNC;
        end
        VSYNC: begin
          fieldLineDot <= '0;
          fieldLine    <= '0;
          lineAdvanced <= 1'b0;
          fieldFull    <= 1'b0;
          if (vsFall) begin
            state      <= ACTIVE;
            locked     <= 1'b1;
            fieldStart <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vsRise) begin
            state <= VSYNC;
          end else if (displayEnabled) begin
            if (dotWrap) begin
              fieldLineDot <= '0;
              lineAdvanced <= 1'b1;
            end else begin
              fieldLineDot <= fieldLineDot + ONE;
            end
          end else if (deFall) begin
            if (shortEnd) begin
              fieldLineDot <= '0;
              shortLine    <= 1'b1;
            end
            lineAdvanced <= 1'b0;
          end

          if (lineAdvReq) begin
            if (!atLastLine)     fieldLine    <= fieldLine + ONE;
            else if (!fieldFull) fieldFull    <= 1'b1;
            else                 lineOverflow <= 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase

      if (vsRise) begin
        lineOverflow <= 1'b0;
        if (INTERLACED != 0) isFieldOdd <= oddAtVs;
      end
    end
  end

`ifdef VIDEO_TRACKER_STATS_EN
  logic       shortEvt;
  logic       ovfEvt;
  logic [8:0] errSum;

  assign shortEvt = activeDe & shortEnd;
  assign ovfEvt   = lineAdvReq & atLastLine & fieldFull & ~lineOverflow;
  assign errSum   = {1'b0, errorCount} + 9'(shortEvt) + 9'(ovfEvt);

  always_ff @(posedge pixelClockX6 or posedge reset) begin
    if (reset) begin
      lastFieldLines <= '0;
      errorCount     <= '0;
    end else if (tick) begin
      if (vsRise) lastFieldLines <= fieldLine + COORD_W'(fieldFull);
      errorCount <= errSum[8] ? 8'hFF : errSum[7:0];
    end
  end
`else
  assign lastFieldLines = '0;
  assign errorCount     = '0;
`endif

endmodule
